// File: rtl/pico_mem_wb_master_if.sv
// Wishbone classic bus bundle between pico_mem_wb_master (master modport)
// and the addressed slave (slave modport).
interface pico_mem_wb_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/pico_mem_wb_master.sv
// PicoRV32 native memory port to Wishbone classic master, one transfer in flight.
// Optional bus timeout is compiled in when WB_TIMEOUT_EN is defined.
module pico_mem_wb_master #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_W      = 8,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic                 bus_err_o,
  input  logic                 bus_err_clr,
  pico_mem_wb_master_if.master wbm
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  // Byte lanes within the word are carried by sel, so the low address bits are dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  if (TIMEOUT_CYCLES < 1 || (TIMEOUT_W < 31 && (1 << TIMEOUT_W) <= TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("pico_mem_wb_master: TIMEOUT_CYCLES must be >=1 and fit in TIMEOUT_W bits");
  end

`ifdef WB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));

  // Held at zero while idle so every BUS phase starts counting from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_BUS && !wbm.wbm_ack_i && !wbm.wbm_err_i) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q (or idle value), so no branch can infer a latch.
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = bus_err_clr ? 1'b0 : err_q;  // a set in S_BUS below overrides the clear

    unique case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          we_d    = |mem_wstrb;
          sel_d   = (|mem_wstrb) ? mem_wstrb : 4'hF;
          adr_d   = {mem_addr[31:2], 2'b00};
          dat_d   = mem_wdata;
        end
      end
      S_BUS: begin
        if (wbm.wbm_ack_i || wbm.wbm_err_i || timeout_hit) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          // Error beats a simultaneous ack; a timeout only aborts when no ack arrived.
          if (wbm.wbm_err_i || !wbm.wbm_ack_i) begin
            rdata_d = ERR_RDATA;
            err_d   = 1'b1;
          end else begin
            rdata_d = we_q ? 32'h0 : wbm.wbm_dat_i;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign mem_ready     = ready_q;
  assign mem_rdata     = rdata_q;
  assign bus_err_o     = err_q;

endmodule

// File: tb/tb_pico_mem_wb_master.sv
// Scoreboard bench for pico_mem_wb_master: directed requests push expected bus
// and response records; a negedge monitor pops and compares them.
module tb_pico_mem_wb_master;

  localparam int          TO_CYC = 8;
  localparam logic [31:0] ERR_RD = 32'hFFFF_FFFF;

  typedef enum int {SL_ACK, SL_ERR, SL_ERRACK, SL_NONE} sl_mode_e;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    int          len;
  } wb_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err_o;
  logic        bus_err_clr = 1'b0;

  pico_mem_wb_master_if wbm ();

  pico_mem_wb_master #(
    .TIMEOUT_CYCLES (TO_CYC),
    .TIMEOUT_W      (4),
    .ERR_RDATA      (ERR_RD)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .bus_err_o   (bus_err_o),
    .bus_err_clr (bus_err_clr),
    .wbm         (wbm)
  );

  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_bad = 0;
  int       cyc_cnt = 0;
  wb_exp_t  wb_q[$];
  rsp_exp_t rsp_q[$];
  sl_mode_e sl_mode = SL_ACK;
  int       sl_waits = 0;
  logic [31:0] sl_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Slave model: answers once the BUS phase has lasted sl_waits wait states.
  initial begin
    int cnt = 0;
    wbm.wbm_ack_i = 1'b0;
    wbm.wbm_err_i = 1'b0;
    wbm.wbm_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      wbm.wbm_ack_i = 1'b0;
      wbm.wbm_err_i = 1'b0;
      wbm.wbm_dat_i = 32'h0;
      if (wbm.wbm_cyc_o && wbm.wbm_stb_o) begin
        if (cnt == sl_waits) begin
          case (sl_mode)
            SL_ACK:    begin wbm.wbm_ack_i = 1'b1; wbm.wbm_dat_i = sl_data; end
            SL_ERR:    wbm.wbm_err_i = 1'b1;
            SL_ERRACK: begin wbm.wbm_ack_i = 1'b1; wbm.wbm_err_i = 1'b1; wbm.wbm_dat_i = sl_data; end
            default:   ;
          endcase
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares bus phases and responses against the scoreboard queues.
  initial begin
    wb_exp_t  cur = '{32'h0, 4'h0, 1'b0, 32'h0, 0};
    rsp_exp_t r;
    int       len = 0;
    logic     stable = 1'b1;
    logic     prev_cyc = 1'b0;
    logic     prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (wbm.wbm_cyc_o && !prev_cyc) begin
        check("cyc_expected", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) begin
          cur = wb_q.pop_front();
          check("wb_adr", wbm.wbm_adr_o, cur.adr);
          check("wb_sel", 32'(wbm.wbm_sel_o), 32'(cur.sel));
          check("wb_we",  32'(wbm.wbm_we_o), 32'(cur.we));
          check("wb_dat", wbm.wbm_dat_o, cur.dat);
        end
        len = 0;
        stable = 1'b1;
      end
      if (wbm.wbm_cyc_o) begin
        len++;
        if (!wbm.wbm_stb_o || wbm.wbm_adr_o !== cur.adr || wbm.wbm_sel_o !== cur.sel ||
            wbm.wbm_we_o !== cur.we || wbm.wbm_dat_o !== cur.dat) stable = 1'b0;
      end
      if (!wbm.wbm_cyc_o && prev_cyc) begin
        check("cyc_length", 32'(len), 32'(cur.len));
        check("bus_stable", 32'(stable), 32'd1);
      end
      if (mem_ready) begin
        check("ready_one_cycle", 32'(prev_rdy), 32'd0);
        check("ready_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          check("mem_rdata", mem_rdata, r.rdata);
          check("bus_err_at_ready", 32'(bus_err_o), 32'(r.err));
          check("ready_cycle", 32'(cyc_cnt), 32'(r.cycle));
        end
      end
      prev_cyc = wbm.wbm_cyc_o;
      prev_rdy = mem_ready;
    end
  end

  // Issue one core request; mem_valid stays high on return (caller releases or chains).
  task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input sl_mode_e mode, input int waits, input logic [31:0] sdata,
                     input logic [31:0] e_adr, input logic [3:0] e_sel, input logic e_we,
                     input logic [31:0] e_rd, input logic e_err, input int len,
                     input bit drop_early);
    int t;
    @(posedge clk);
    #1;
    sl_mode  = mode;
    sl_waits = waits;
    sl_data  = sdata;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    wb_q.push_back('{e_adr, e_sel, e_we, wdata, len});
    rsp_q.push_back('{e_rd, e_err, cyc_cnt + 1 + len});
    if (drop_early) begin
      @(posedge clk);
      #1 mem_valid = 1'b0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_ready && t < 2000);
    check("ready_seen", 32'(mem_ready), 32'd1);
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  // Start a read the slave never answers, keep it on the bus n cycles, then reset for one cycle.
  task automatic hang_reset(input int n);
    @(posedge clk);
    #1;
    sl_mode   = SL_NONE;
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0100;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    wb_q.push_back('{32'h0000_0100, 4'hF, 1'b0, 32'h0, n});
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    mem_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cyc_low", 32'(wbm.wbm_cyc_o), 32'd0);
    check("rst_stb_low", 32'(wbm.wbm_stb_o), 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_bus_err", 32'(bus_err_o), 32'd0);
    sl_mode = SL_ACK;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cyc",   32'(wbm.wbm_cyc_o), 32'd0);
    check("reset_stb",   32'(wbm.wbm_stb_o), 32'd0);
    check("reset_we",    32'(wbm.wbm_we_o), 32'd0);
    check("reset_sel",   32'(wbm.wbm_sel_o), 32'd0);
    check("reset_adr",   wbm.wbm_adr_o, 32'h0);
    check("reset_dat",   wbm.wbm_dat_o, 32'h0);
    check("reset_ready", 32'(mem_ready), 32'd0);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_err",   32'(bus_err_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait read: mem_ready two cycles after mem_valid is first presented.
    req(32'h1000_0008, 32'h0, 4'h0, SL_ACK, 0, 32'h1234_5678,
        32'h1000_0008, 4'hF, 1'b0, 32'h1234_5678, 1'b0, 1, 1'b0);
    release_req();

    // Unaligned write with 4 wait states; write responses return 0 whatever dat_i holds.
    req(32'h3000_0006, 32'hAABB_CCDD, 4'b1100, SL_ACK, 4, 32'hDEAD_BEEF,
        32'h3000_0004, 4'hC, 1'b1, 32'h0, 1'b0, 5, 1'b0);
    release_req();

    // Back-to-back reads with mem_valid held between them.
    req(32'h2000_0000, 32'h0, 4'h0, SL_ACK, 1, 32'hCAFE_F00D,
        32'h2000_0000, 4'hF, 1'b0, 32'hCAFE_F00D, 1'b0, 2, 1'b0);
    req(32'h2000_0004, 32'h0, 4'h0, SL_ACK, 0, 32'h0BAD_BEEF,
        32'h2000_0004, 4'hF, 1'b0, 32'h0BAD_BEEF, 1'b0, 1, 1'b0);
    release_req();

    // err together with ack: error data, sticky flag until a clear pulse.
    req(32'h4000_0010, 32'h0, 4'h0, SL_ERRACK, 0, 32'h5555_5555,
        32'h4000_0010, 4'hF, 1'b0, ERR_RD, 1'b1, 1, 1'b0);
    release_req();
    repeat (3) @(negedge clk);
    check("bus_err_sticky", 32'(bus_err_o), 32'd1);
    @(posedge clk);
    #1 bus_err_clr = 1'b1;
    @(posedge clk);
    #1 bus_err_clr = 1'b0;
    @(negedge clk);
    check("bus_err_cleared", 32'(bus_err_o), 32'd0);

    // Clear held high across an erroring write: the set on the err edge wins.
    bus_err_clr = 1'b1;
    req(32'h5000_0000, 32'h0000_0011, 4'b0001, SL_ERR, 2, 32'h0,
        32'h5000_0000, 4'h1, 1'b1, ERR_RD, 1'b1, 3, 1'b0);
    release_req();
    bus_err_clr = 1'b0;
    @(negedge clk);
    check("bus_err_clr_after", 32'(bus_err_o), 32'd0);

    // mem_valid dropped mid-BUS: the Wishbone cycle completes and mem_ready still pulses.
    req(32'h7000_0020, 32'h0102_0304, 4'b0011, SL_ACK, 2, 32'h0,
        32'h7000_0020, 4'h3, 1'b1, 32'h0, 1'b0, 3, 1'b1);
    release_req();

`ifdef WB_TIMEOUT_EN
    // Ack on the very cycle the counter reaches TIMEOUT_CYCLES completes normally.
    req(32'h0800_0000, 32'h0, 4'h0, SL_ACK, TO_CYC, 32'h7777_0000,
        32'h0800_0000, 4'hF, 1'b0, 32'h7777_0000, 1'b0, TO_CYC + 1, 1'b0);
    release_req();
    // No answer at all: abort after TIMEOUT_CYCLES+1 bus cycles.
    req(32'h0800_0004, 32'h0, 4'h0, SL_NONE, 0, 32'h0,
        32'h0800_0004, 4'hF, 1'b0, ERR_RD, 1'b1, TO_CYC + 1, 1'b0);
    release_req();
    sl_mode = SL_ACK;
`else
    // Without the timeout the cycle stays open; recover it with a reset.
    hang_reset(1000);
`endif

    hang_reset(3);

    req(32'h6000_000C, 32'h0, 4'h0, SL_ACK, 0, 32'h0123_4567,
        32'h6000_000C, 4'hF, 1'b0, 32'h0123_4567, 1'b0, 1, 1'b0);
    release_req();

    repeat (5) @(negedge clk);
    check("wb_queue_drained",  32'(wb_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
